serial_subtractor: RTL and testbench



---
 rtl/serial_sub_pkg.sv | 13 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 108 ++++++++++
 tb/tb_serial_subtractor.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: difference = a - b - bin, with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic difference,
  output logic borrow
);

  assign difference = a ^ b ^ bin;
  assign borrow     = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: a - b - bin computed LSB-first, one bit per
// clock, through a single full_subtractor cell, with valid/ready on both sides.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] difference,
  output logic             borrow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             br_q;
  logic [CW-1:0]    cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             cell_d;
  logic             cell_bo;

  full_subtractor u_cell (
    .a          (a_q[0]),
    .b          (b_q[0]),
    .bin        (br_q),
    .difference (cell_d),
    .borrow     (cell_bo)
  );

  // FSM, shift registers, borrow register and registered handshake flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      br_q        <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          out_valid_q <= 1'b0;
          if (in_valid && in_ready_q) begin
            a_q        <= a;
            b_q        <= b;
            br_q       <= bin;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= SHIFT;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        SHIFT: begin
          // Result fills from the MSB so bit 0 lands in place after WIDTH shifts.
          a_q        <= {1'b0, a_q[WIDTH-1:1]};
          b_q        <= {1'b0, b_q[WIDTH-1:1]};
          res_q      <= {cell_d, res_q[WIDTH-1:1]};
          br_q       <= cell_bo;
          cnt_q      <= cnt_q + CW'(1);
          in_ready_q <= 1'b0;
          if (cnt_q == LAST_BIT) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            out_valid_q <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end else begin
            out_valid_q <= 1'b1;
            in_ready_q  <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign difference = res_q;
  assign borrow     = br_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH = 8): directed vectors plus a
// random sweep with output backpressure.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] difference;
  logic         borrow;

  int           errors = 0;
  int           checks = 0;
  logic [W:0]   exp_q[$];
  logic         bp_en = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .bin        (bin),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .difference (difference),
    .borrow     (borrow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                      input logic push, input logic [W:0] expv);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    check("in_ready_wait", 32'(n < 100), 32'd1);
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    bin      = cv;
    @(posedge clk);
    if (push) exp_q.push_back(expv);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    tick();
  endtask

  // Pops the expected result whenever the DUT completes an output handshake.
  task automatic monitor();
    logic [W:0] e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: actual=%0h required=none", {borrow, difference});
        end else begin
          e = exp_q.pop_front();
          check("result", {23'd0, borrow, difference}, {23'd0, e});
        end
      end
    end
  endtask

  task automatic bp_driver();
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    int          cyc;
    logic [W-1:0] av;
    logic [W-1:0] bv;
    logic         cv;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    out_ready = 1'b0;

    fork
      monitor();
      bp_driver();
      begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "simulation time limit reached");
      end
    join_none

    repeat (3) tick();
    check("in_ready_in_reset", 32'(in_ready), 32'd0);
    check("out_valid_in_reset", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_difference", 32'(difference), 32'h00);
    check("idle_borrow", 32'(borrow), 32'd0);

    out_ready = 1'b1;
    send(8'h05, 8'h03, 1'b0, 1'b1, 9'h002);
    wait_valid(cyc);
    check("latency", 32'(cyc), 32'd8);
    send(8'h03, 8'h05, 1'b0, 1'b1, 9'h1FE);
    send(8'h00, 8'h00, 1'b1, 1'b1, 9'h1FF);
    drain();

    // Stall with out_ready low; a stray in_valid pulse during SHIFT must be ignored.
    out_ready = 1'b0;
    send(8'hFF, 8'hFF, 1'b0, 1'b1, 9'h000);
    tick();
    tick();
    in_valid = 1'b1;
    a        = 8'h12;
    b        = 8'h34;
    bin      = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid(cyc);
    for (int i = 0; i < 5; i++) begin
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_difference", 32'(difference), 32'h00);
      check("stall_borrow", 32'(borrow), 32'd0);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    repeat (12) tick();
    check("no_phantom_result", 32'(out_valid), 32'd0);

    // Reset after three bits have been processed discards the operation.
    send(8'h55, 8'h22, 1'b0, 1'b0, 9'h000);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    check("midreset_difference", 32'(difference), 32'h00);
    check("midreset_borrow", 32'(borrow), 32'd0);
    tick();
    check("after_reset_in_ready", 32'(in_ready), 32'd1);
    check("after_reset_out_valid", 32'(out_valid), 32'd0);
    send(8'h80, 8'h01, 1'b0, 1'b1, 9'h07F);
    drain();

    bp_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      av = W'($urandom);
      bv = W'($urandom);
      cv = 1'($urandom_range(0, 1));
      send(av, bv, cv, 1'b1, {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, cv});
    end
    bp_en     = 1'b0;
    out_ready = 1'b1;
    drain();
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
